// File: rtl/axi_interconnect_crossbar_wr_sched.sv
// Write-channel scheduler for one crossbar slave port.
// Round-robin AW arbitration, grant held through the W burst, and an
// in-order FIFO of granted masters that steers B responses back.
module axi_interconnect_crossbar_wr_sched #(
    parameter int NUM             = 4,
    parameter int WIDTH           = $clog2(NUM),
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [NUM-1:0]   m_awvalid,
    output logic [NUM-1:0]   m_awready,
    output logic             s_awvalid,
    input  logic             s_awready,
    input  logic [NUM-1:0]   m_wvalid,
    input  logic [NUM-1:0]   m_wlast,
    output logic [NUM-1:0]   m_wready,
    output logic             s_wvalid,
    output logic             s_wlast,
    input  logic             s_wready,
    input  logic             s_bvalid,
    output logic             s_bready,
    output logic [NUM-1:0]   m_bvalid,
    input  logic [NUM-1:0]   m_bready,
    output logic [WIDTH-1:0] aw_sel,
    output logic [WIDTH-1:0] w_sel,
    output logic [WIDTH-1:0] b_sel,
    output logic             err_unexp_b
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, AW, W} state_t;

    state_t           state;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] last_user;
    logic [WIDTH-1:0] winner;
    logic [WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             not_empty;
    logic             full;
    logic             aw_hs;
    logic             w_last_hs;
    logic             b_hs;

    assign not_empty = (count != '0);
    assign full      = (count == CW'(MAX_OUTSTANDING));
    assign aw_hs     = (state == AW) && m_awvalid[grant] && s_awready;
    assign w_last_hs = (state == W) && m_wvalid[grant] && s_wready && m_wlast[grant];
    assign b_hs      = s_bvalid && s_bready;

    assign aw_sel = grant;
    assign w_sel  = grant;
    assign b_sel  = fifo_mem[rd_ptr];

    // Round-robin search: first requester after last_user, wrapping at NUM-1.
    always_comb begin
        int  idx;
        logic found;
        winner = last_user;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM; i++) begin
            idx = (int'(last_user) + i) % NUM;
            if (!found && m_awvalid[idx]) begin
                winner = WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    // Handshake pass-throughs, steered only by registered grant/state/FIFO head.
    always_comb begin
        m_awready   = '0;
        m_wready    = '0;
        m_bvalid    = '0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_wlast     = 1'b0;
        s_bready    = 1'b0;
        err_unexp_b = s_bvalid && !not_empty;
        if (state == AW) begin
            s_awvalid        = m_awvalid[grant];
            m_awready[grant] = s_awready;
        end
        if (state == W) begin
            s_wvalid        = m_wvalid[grant];
            s_wlast         = m_wlast[grant];
            m_wready[grant] = s_wready;
        end
        if (not_empty) begin
            m_bvalid[b_sel] = s_bvalid;
            s_bready        = m_bready[b_sel];
        end
    end

    // Arbitration FSM: latch a winner, pass AW, hold grant until wlast beat.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            last_user <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_awvalid && !full) begin
                        grant <= winner;
                        state <= AW;
                    end
                end
                AW: begin
                    if (aw_hs) state <= W;
                end
                W: begin
                    if (w_last_hs) begin
                        last_user <= grant;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding-response FIFO: push granted master on AW, pop on B handshake.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                fifo_mem[wr_ptr] <= grant;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (b_hs) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({aw_hs, b_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_interconnect_crossbar_wr_sched.sv
// Directed bench for the crossbar write scheduler (NUM=4, MAX_OUTSTANDING=2).
module tb_axi_interconnect_crossbar_wr_sched;
    logic       clk_sys = 1'b0;
    logic       rst;
    logic [3:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic       s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [1:0] aw_sel, w_sel, b_sel;
    logic       err_unexp_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] exp_order [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    axi_interconnect_crossbar_wr_sched #(.NUM(4), .MAX_OUTSTANDING(2)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .aw_sel(aw_sel), .w_sel(w_sel), .b_sel(b_sel),
        .err_unexp_b(err_unexp_b)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #2;
    endtask

    task automatic zero_inputs;
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        zero_inputs();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [16:0] all_outs();
        return {m_awready, s_awvalid, m_wready, s_wvalid, s_wlast, s_bready, m_bvalid, err_unexp_b};
    endfunction

    initial begin
        int         ng, nb, beats, hs;
        logic [1:0] ord [5];
        logic       tog, aw_done, done;
        logic [3:0] clr;

        // Reset state
        rst = 1'b1;
        zero_inputs();
        tick();
        tick();
        #1;
        chk("rst_outs", all_outs(), 0);
        chk("rst_sels", {aw_sel, w_sel, b_sel}, 0);
        chk("rst_count", dut.count, 0);
        chk("rst_last_user", dut.last_user, 0);

        // 1: masters 0 and 2 request; search from 1 picks 2
        rst = 1'b0;
        m_awvalid = 4'b0101; s_awready = 1'b1; s_wready = 1'b1;
        m_wvalid = 4'b0100; m_wlast = 4'b0100;
        #1;
        chk("s1_idle_no_awvalid", s_awvalid, 0);
        tick(); #1;
        chk("s1_aw_sel", aw_sel, 2);
        chk("s1_s_awvalid", s_awvalid, 1);
        chk("s1_m_awready", m_awready, 4'b0100);
        tick(); m_awvalid = '0; #1;
        chk("s1_s_wvalid", s_wvalid, 1);
        chk("s1_s_wlast", s_wlast, 1);
        chk("s1_m_wready", m_wready, 4'b0100);
        chk("s1_w_sel", w_sel, 2);
        chk("s1_count", dut.count, 1);
        chk("s1_b_sel", b_sel, 2);
        tick(); #1;
        chk("s1_last_user", dut.last_user, 2);
        chk("s1_idle_wvalid", s_wvalid, 0);
        s_bvalid = 1'b1; m_bready = 4'b0100; #1;
        chk("s1_m_bvalid", m_bvalid, 4'b0100);
        chk("s1_s_bready", s_bready, 1);
        chk("s1_err", err_unexp_b, 0);
        tick(); s_bvalid = 1'b0; m_bready = '0; #1;
        chk("s1_count_after_pop", dut.count, 0);

        // 6: reset during beat 2 of a burst from master 2 (last_user=2 beforehand)
        m_awvalid = 4'b0100; m_wvalid = 4'b0100; m_wlast = '0;
        s_awready = 1'b1; s_wready = 1'b1;
        tick(); #1;
        chk("s6_aw_sel", aw_sel, 2);
        tick(); m_awvalid = '0; #1;
        chk("s6_count", dut.count, 1);
        tick(); #1;
        chk("s6_beat2_wvalid", s_wvalid, 1);
        rst = 1'b1;
        tick(); #1;
        chk("s6_rst_outs", all_outs(), 0);
        chk("s6_rst_sels", {aw_sel, w_sel, b_sel}, 0);
        chk("s6_rst_count", dut.count, 0);
        rst = 1'b0; m_wvalid = '0; m_awvalid = 4'b0011;
        tick(); #1;
        chk("s6_rr_restart", aw_sel, 1);
        chk("s6_rr_awvalid", s_awvalid, 1);
        do_reset();

        // 2: all request, slave always ready, B every cycle
        m_awvalid = 4'b1111; m_wvalid = 4'b1111; m_wlast = 4'b1111;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = 4'b1111;
        ng = 0; nb = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (s_awvalid && s_awready) begin
                ord[ng] = aw_sel;
                ng++;
            end
            if (m_bvalid != '0 && nb < 5) begin
                chk("s2_b_route", m_bvalid, 4'b0001 << exp_order[nb]);
                nb++;
            end
            tick();
        end
        chk("s2_grants_seen", ng, 5);
        for (int i = 0; i < 5; i++) chk("s2_grant_order", ord[i], exp_order[i]);
        do_reset();

        // 3: 4-beat burst from master 3 with s_wready toggling
        m_awvalid = 4'b1000; m_wvalid = 4'b1000; s_awready = 1'b1;
        tog = 1'b1; aw_done = 1'b0; done = 1'b0; beats = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (aw_done) m_awvalid = '0;
            s_wready = tog;
            m_wlast = (beats == 3) ? 4'b1000 : 4'b0000;
            #1;
            if (s_awvalid && s_awready) aw_done = 1'b1;
            if (s_wvalid) chk("s3_other_wready", m_wready[2:0], 0);
            if (s_wvalid && s_wready) begin
                chk("s3_wlast", s_wlast, (beats == 3));
                beats++;
                if (s_wlast) done = 1'b1;
            end
            tog = ~tog;
            tick();
        end
        #1;
        chk("s3_beats", beats, 4);
        chk("s3_done", done, 1);
        chk("s3_idle_wvalid", s_wvalid, 0);
        do_reset();

        // 4: two writes with no B fill the FIFO; third waits until a pop
        m_awvalid = 4'b1110; m_wvalid = 4'b1111; m_wlast = 4'b1111;
        s_awready = 1'b1; s_wready = 1'b1;
        clr = '0; hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            m_awvalid = m_awvalid & ~clr;
            #1;
            if (s_awvalid && s_awready) begin
                ord[hs] = aw_sel;
                clr = m_awready;
                hs++;
            end
            tick();
        end
        m_awvalid = m_awvalid & ~clr;
        tick();
        chk("s4_hs", hs, 2);
        chk("s4_first", ord[0], 1);
        chk("s4_second", ord[1], 2);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("s4_blocked", s_awvalid, 0);
            tick();
        end
        chk("s4_count_full", dut.count, 2);
        s_bvalid = 1'b1; m_bready = 4'b1111; #1;
        chk("s4_b0_route", m_bvalid, 4'b0010);
        chk("s4_b0_ready", s_bready, 1);
        chk("s4_b0_noaw", s_awvalid, 0);
        tick(); #1;
        chk("s4_b1_route", m_bvalid, 4'b0100);
        chk("s4_b1_noaw", s_awvalid, 0);
        tick(); s_bvalid = 1'b0; #1;
        chk("s4_third_awvalid", s_awvalid, 1);
        chk("s4_third_sel", aw_sel, 3);
        chk("s4_count_drained", dut.count, 0);
        do_reset();

        // 5: unexpected B with empty FIFO
        s_bvalid = 1'b1; m_bready = 4'b1111; #1;
        chk("s5_err", err_unexp_b, 1);
        chk("s5_s_bready", s_bready, 0);
        chk("s5_m_bvalid", m_bvalid, 0);
        s_bvalid = 1'b0; #1;
        chk("s5_err_clear", err_unexp_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
